dlatch_wr_ctrl: RTL and testbench

Write controller that sits directly upstream of the D-latch bank and owns its D and En inputs. It accepts data words over a valid/ready handshake and drives each word onto D. It then opens En for a programmed number of clock cycles, with programmed setup and hold margins around the pulse, so the latch always samples stable data. An optional readback checker compares the latch Q output against the written word.

---
 rtl/dlatch_wr_ctrl_if.sv | 12 +
 rtl/dlatch_wr_ctrl.sv | 117 +++++++++++
 tb/tb_dlatch_wr_ctrl.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/dlatch_wr_ctrl_if.sv
// Write-side handshake bundle for dlatch_wr_ctrl: a data word offered with
// valid and accepted with ready.
interface dlatch_wr_ctrl_if #(
    parameter int unsigned WIDTH = 8
);
    logic [WIDTH-1:0] in_data;
    logic             in_valid;
    logic             in_ready;

    modport master (output in_data, output in_valid, input in_ready);
    modport slave  (input in_data, input in_valid, output in_ready);
endinterface

// File: rtl/dlatch_wr_ctrl.sv
// D-latch bank write controller: drives D and a timed En pulse with setup/hold margins.
// Optional readback compare of the latch Q output is enabled by DLATCH_WR_CTRL_READBACK_EN.
module dlatch_wr_ctrl #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned SETUP = 2,
    parameter int unsigned PULSE = 3,
    parameter int unsigned HOLD  = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    dlatch_wr_ctrl_if.slave       bus,
    output logic [WIDTH-1:0]      d,
    output logic                  en,
    output logic                  busy,
    output logic                  done,
    input  logic [WIDTH-1:0]      q_in,
    output logic                  err
);

    localparam int unsigned CNT_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SETUP = 2'd1,
        ST_PULSE = 2'd2,
        ST_HOLD  = 2'd3
    } state_t;

    state_t             state, state_nx;
    logic [CNT_W-1:0]   cnt, cnt_nx;
    logic [WIDTH-1:0]   d_nx;
    logic               en_nx;
    logic               done_nx;
    logic               err_nx;

    // State register and registered outputs; en resets asynchronously so an abort drops it at once
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            cnt   <= '0;
            d     <= '0;
            en    <= 1'b0;
            done  <= 1'b0;
            err   <= 1'b0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            d     <= d_nx;
            en    <= en_nx;
            done  <= done_nx;
            err   <= err_nx;
        end
    end

    // Next-state and next-output logic; one shared down-counter times every phase
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        d_nx     = d;
        en_nx    = en;
        done_nx  = 1'b0;
        err_nx   = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (bus.in_valid) begin
                    state_nx = ST_SETUP;
                    d_nx     = bus.in_data;
                    cnt_nx   = CNT_W'(SETUP - 1);
                    en_nx    = 1'b0;
                end
            end
            ST_SETUP: begin
                if (cnt == '0) begin
                    state_nx = ST_PULSE;
                    en_nx    = 1'b1;
                    cnt_nx   = CNT_W'(PULSE - 1);
                end else begin
                    cnt_nx   = cnt - CNT_W'(1);
                end
            end
            ST_PULSE: begin
                if (cnt == '0) begin
                    state_nx = ST_HOLD;
                    en_nx    = 1'b0;
                    cnt_nx   = CNT_W'(HOLD - 1);
                end else begin
                    cnt_nx   = cnt - CNT_W'(1);
                end
            end
            ST_HOLD: begin
                if (cnt == '0) begin
                    state_nx = ST_IDLE;
                    done_nx  = 1'b1;
`ifdef DLATCH_WR_CTRL_READBACK_EN
                    err_nx   = (q_in != d);
`endif
                end else begin
                    cnt_nx   = cnt - CNT_W'(1);
                end
            end
            default: begin
                state_nx = ST_IDLE;
                en_nx    = 1'b0;
            end
        endcase
    end

`ifndef DLATCH_WR_CTRL_READBACK_EN
    // Readback input has no load in this build
    logic unused_q_in;
    assign unused_q_in = ^q_in;
`endif

    assign bus.in_ready = (state == ST_IDLE);
    assign busy         = (state != ST_IDLE);

endmodule

// File: tb/tb_dlatch_wr_ctrl.sv
// Self-checking bench for dlatch_wr_ctrl: per-cycle waveform checks plus a
// scoreboard of written words popped on each done pulse.
module tb_dlatch_wr_ctrl;

    localparam int unsigned WIDTH = 8;
    localparam int unsigned SETUP = 2;
    localparam int unsigned PULSE = 3;
    localparam int unsigned HOLD  = 1;
    localparam int unsigned SEQ   = SETUP + PULSE + HOLD;
`ifdef DLATCH_WR_CTRL_READBACK_EN
    localparam bit RB = 1'b1;
`else
    localparam bit RB = 1'b0;
`endif

    typedef struct {
        logic [WIDTH-1:0] data;
        logic             err;
    } exp_t;

    exp_t             sb[$];
    logic             clk = 1'b0;
    logic             rst_n = 1'b1;
    logic [WIDTH-1:0] d;
    logic [WIDTH-1:0] q_in;
    logic             en, busy, done, err;
    int               checks = 0;
    int               errors = 0;

    dlatch_wr_ctrl_if #(.WIDTH(WIDTH)) bus ();

    dlatch_wr_ctrl #(
        .WIDTH(WIDTH), .SETUP(SETUP), .PULSE(PULSE), .HOLD(HOLD)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus),
        .d     (d),
        .en    (en),
        .busy  (busy),
        .done  (done),
        .q_in  (q_in),
        .err   (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard side: each done pops the oldest accepted word
    always @(negedge clk) begin
        exp_t e;
        if (rst_n === 1'b1) begin
            if (done) begin
                if (sb.size() == 0) begin
                    check("done_unexpected", 32'(done), 32'(0));
                end else begin
                    e = sb.pop_front();
                    check("sb_data", 32'(d), 32'(e.data));
                    check("sb_err", 32'(err), 32'(e.err));
                end
            end else begin
                check("err_quiet", 32'(err), 32'(0));
            end
            if (en && sb.size() > 0)
                check("d_stable_en", 32'(d), 32'(sb[0].data));
        end
    end

    // Offer a word and wait for acceptance; valid is left high for the caller
    task automatic write_word(input logic [WIDTH-1:0] data, input logic [WIDTH-1:0] q);
        exp_t e;
        bit   ok;
        ok = 1'b0;
        bus.in_data  = data;
        bus.in_valid = 1'b1;
        for (int i = 0; i < 100 && !ok; i++) begin
            if (bus.in_ready) begin
                q_in   = q;
                e.data = data;
                e.err  = RB ? (q != data) : 1'b0;
                sb.push_back(e);
                ok = 1'b1;
            end
            step();
        end
        if (!ok) check("ready_timeout", 32'(0), 32'(1));
    endtask

    // Called in cycle 1 after a transfer; returns in the done cycle without stepping past it
    task automatic check_seq(input logic [WIDTH-1:0] data, input bit toggle, input bit exp_err);
        for (int c = 1; c <= int'(SEQ) + 1; c++) begin
            check("seq_d", 32'(d), 32'(data));
            check("seq_en", 32'(en), 32'((c >= int'(1 + SETUP)) && (c <= int'(SETUP + PULSE))));
            check("seq_done", 32'(done), 32'(c == int'(SEQ) + 1));
            check("seq_ready", 32'(bus.in_ready), 32'(c == int'(SEQ) + 1));
            check("seq_busy", 32'(busy), 32'(c <= int'(SEQ)));
            check("seq_err", 32'(err), 32'((c == int'(SEQ) + 1) ? exp_err : 1'b0));
            if (toggle) begin
                bus.in_valid = (c <= int'(SEQ)) ? ((c % 2) == 1) : 1'b0;
                bus.in_data  = WIDTH'($urandom);
            end
            if (c <= int'(SEQ)) step();
        end
    endtask

    initial begin
        bus.in_valid = 1'b1;
        bus.in_data  = 8'h55;
        q_in         = '0;
        #1 rst_n = 1'b0;

        // Reset held with valid asserted: nothing is accepted
        for (int i = 0; i < 3; i++) begin
            step();
            check("rst_d", 32'(d), 32'(0));
            check("rst_en", 32'(en), 32'(0));
            check("rst_ready", 32'(bus.in_ready), 32'(1));
            check("rst_done", 32'(done), 32'(0));
        end
        bus.in_valid = 1'b0;
        rst_n = 1'b1;
        step();
        check("rst_no_xfer", 32'(d), 32'(0));
        check("rst_idle", 32'(busy), 32'(0));

        // Single write with matching readback
        write_word(8'hA5, 8'hA5);
        bus.in_valid = 1'b0;
        check_seq(8'hA5, 1'b0, 1'b0);
        step();

        // Back-to-back: second word accepted on the done edge
        write_word(8'h3C, 8'h3C);
        check_seq(8'h3C, 1'b0, 1'b0);
        write_word(8'hC3, 8'hC3);
        check_seq(8'hC3, 1'b0, 1'b0);
        bus.in_valid = 1'b0;
        step();

        // Input activity during a sequence is ignored
        write_word(8'h5A, 8'h5A);
        bus.in_valid = 1'b0;
        check_seq(8'h5A, 1'b1, 1'b0);
        step();
        check("ign_ready", 32'(bus.in_ready), 32'(1));
        check("ign_d", 32'(d), 32'(8'h5A));

        // Readback mismatch flags err only in the done cycle
        write_word(8'hA5, 8'hA4);
        bus.in_valid = 1'b0;
        check_seq(8'hA5, 1'b0, RB);
        step();
        check("rb_err_clear", 32'(err), 32'(0));

        // Asynchronous reset in the middle of the pulse
        write_word(8'h96, 8'h96);
        bus.in_valid = 1'b0;
        for (int i = 0; i < 3; i++) step();
        check("abort_en_before", 32'(en), 32'(1));
        rst_n = 1'b0;
        #1;
        check("abort_en", 32'(en), 32'(0));
        check("abort_ready", 32'(bus.in_ready), 32'(1));
        check("abort_d", 32'(d), 32'(0));
        sb.delete();
        for (int i = 0; i < 2; i++) begin
            step();
            check("abort_done", 32'(done), 32'(0));
        end
        rst_n = 1'b1;
        for (int i = 0; i < SEQ + 2; i++) begin
            step();
            check("abort_idle_ready", 32'(bus.in_ready), 32'(1));
            check("abort_no_done", 32'(done), 32'(0));
        end

        // Sequencing works again after an abort
        write_word(8'h0F, 8'h0F);
        bus.in_valid = 1'b0;
        check_seq(8'h0F, 1'b0, 1'b0);
        step();
        step();
        check("sb_empty", 32'(sb.size()), 32'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
